// File: rtl/reset_sequencer.sv
// Staged reset controller: asynchronous assertion of every channel, clk-synchronised
// deassertion, a minimum hold time, then one channel released every STAGE_GAP cycles.
// A software request re-runs the hold/release sequence without touching the synchroniser.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   SYNC    | waiting for the deassertion synchroniser to fill with ones
//   HOLD    | all channels asserted, hold timer counting down
//   RELEASE | channels being released one per STAGE_GAP cycles
//   DONE    | every channel released, idle until sw_rst_req or rst_n
module reset_sequencer #(
   parameter int                  NUM_CH           = 3,
   parameter int                  SYNC_STAGES      = 2,
   parameter int                  HOLD_CYCLES      = 4,
   parameter int                  STAGE_GAP        = 3,
   parameter logic [NUM_CH-1:0]   ACTIVE_HIGH_MASK = 3'b010,
   parameter int                  CNT_WIDTH        = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sw_rst_req,
   output logic [NUM_CH-1:0]    rst_out,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] seq_count
);

   localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMR_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   // Timer reload values: the terminal-count edge is counted as one of the cycles.
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] LAST_GAP_IDX = IDX_W'(NUM_CH - 2);

   typedef enum logic [1:0] {
      S_SYNC    = 2'd0,
      S_HOLD    = 2'd1,
      S_RELEASE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [IDX_W-1:0]        idx_q, idx_d, idx_nx;
   logic [NUM_CH-1:0]       rel_q, rel_d;
   logic                    done_d;
   logic                    cnt_inc;
   logic                    sync_go;
   logic                    tmr_tc;

   // Go to HOLD on the edge where the last synchroniser stage becomes 1, so that
   // the first released channel lands exactly SYNC_STAGES + HOLD_CYCLES edges in.
   assign sync_go = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
   assign tmr_tc  = (tmr_q == '0);
   assign idx_nx  = idx_q + 1'b1;

   // Deassertion synchroniser: cleared asynchronously, fills with ones while rst_n is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // State, timer, channel index and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_SYNC;
         tmr_q     <= '0;
         idx_q     <= '0;
         rel_q     <= '0;
         rst_out   <= ACTIVE_HIGH_MASK;
         done      <= 1'b0;
         seq_count <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         rel_q   <= rel_d;
         rst_out <= ACTIVE_HIGH_MASK ^ rel_d;
         done    <= done_d;
         if (cnt_inc) begin
            seq_count <= seq_count + 1'b1;
         end
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SYNC: begin
            if (sync_go) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (sw_rst_req)  state_d = S_HOLD;
            else if (tmr_tc) state_d = (NUM_CH == 1) ? S_DONE : S_RELEASE;
         end
         S_RELEASE: begin
            if (sw_rst_req)                             state_d = S_HOLD;
            else if (tmr_tc && (idx_q == LAST_GAP_IDX)) state_d = S_DONE;
         end
         S_DONE: begin
            if (sw_rst_req) state_d = S_HOLD;
         end
         default: state_d = S_SYNC;
      endcase
   end

   // Next values of timer, index, release mask, done and the completion strobe.
   always_comb begin
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      rel_d   = rel_q;
      done_d  = done;
      cnt_inc = 1'b0;
      case (state_q)
         S_SYNC: begin
            if (sync_go) begin
               tmr_d  = HOLD_LOAD;
               rel_d  = '0;
               done_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (sw_rst_req) begin
               tmr_d = HOLD_LOAD;
               rel_d = '0;
            end else if (tmr_tc) begin
               rel_d[0] = 1'b1;
               idx_d    = '0;
               tmr_d    = GAP_LOAD;
               if (NUM_CH == 1) begin
                  done_d  = 1'b1;
                  cnt_inc = 1'b1;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_RELEASE: begin
            if (sw_rst_req) begin
               tmr_d  = HOLD_LOAD;
               rel_d  = '0;
               done_d = 1'b0;
            end else if (tmr_tc) begin
               idx_d = idx_nx;
               tmr_d = GAP_LOAD;
               for (int k = 0; k < NUM_CH; k++) begin
                  if (IDX_W'(k) == idx_nx) rel_d[k] = 1'b1;
               end
               if (idx_q == LAST_GAP_IDX) begin
                  done_d  = 1'b1;
                  cnt_inc = 1'b1;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_DONE: begin
            if (sw_rst_req) begin
               tmr_d  = HOLD_LOAD;
               rel_d  = '0;
               done_d = 1'b0;
            end
         end
         default: begin
            rel_d  = '0;
            done_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default configuration plus a single-channel,
// narrow-counter instance exercising wrap-around.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, sw_rst_req;
   logic [2:0] rst_out;
   logic       done;
   logic [23:0] seq_count;

   logic       rst_n2, sw_rst_req2;
   logic [0:0] rst_out2;
   logic       done2;
   logic [1:0] seq_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reset_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_rst_req (sw_rst_req),
      .rst_out    (rst_out),
      .done       (done),
      .seq_count  (seq_count)
   );

   reset_sequencer #(
      .NUM_CH           (1),
      .SYNC_STAGES      (3),
      .HOLD_CYCLES      (1),
      .STAGE_GAP        (3),
      .ACTIVE_HIGH_MASK (1'b0),
      .CNT_WIDTH        (2)
   ) dut2 (
      .clk        (clk),
      .rst_n      (rst_n2),
      .sw_rst_req (sw_rst_req2),
      .rst_out    (rst_out2),
      .done       (done2),
      .seq_count  (seq_count2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Default-config output pattern n edges after sync release (ch0 at 6, ch1 at 9, ch2 at 12).
   function automatic logic [2:0] exp_out(input int n);
      if (n < 6)       return 3'b010;
      else if (n < 9)  return 3'b011;
      else if (n < 12) return 3'b001;
      else             return 3'b101;
   endfunction

   task automatic run_check(input string tag, input int first, input int last,
                            input int offset, input int base);
      for (int n = first; n <= last; n++) begin
         step();
         check({tag, "_out"},   32'(rst_out),   32'(exp_out(n + offset)));
         check({tag, "_done"},  32'(done),      32'((n + offset) >= 12));
         check({tag, "_count"}, 32'(seq_count), 32'(base + int'((n + offset) >= 12)));
      end
   endtask

   task automatic check_asserted(input string tag, input int cnt);
      check({tag, "_out"},   32'(rst_out),   32'(3'b010));
      check({tag, "_done"},  32'(done),      32'(0));
      check({tag, "_count"}, 32'(seq_count), 32'(cnt));
   endtask

   initial begin
      rst_n       = 1'b1;
      rst_n2      = 1'b1;
      sw_rst_req  = 1'b0;
      sw_rst_req2 = 1'b0;
      #1;
      rst_n  = 1'b0;
      rst_n2 = 1'b0;
      #1;
      check_asserted("reset", 0);
      check("reset2_out",  32'(rst_out2),   32'(0));
      check("reset2_done", 32'(done2),      32'(0));
      check("reset2_cnt",  32'(seq_count2), 32'(0));

      // Power-on: release at t=40, between edges; edge 1 is t=45.
      #38;
      rst_n = 1'b1;
      run_check("pwr", 1, 12, 0, 0);
      step();
      check("pwr_idle_out", 32'(rst_out), 32'(3'b101));

      // Asynchronous assertion 3 ns after an edge while in DONE.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_asserted("async", 0);

      // Restart, then abort between edges 7 and 8.
      #1;
      rst_n = 1'b1;
      run_check("abort_pre", 1, 7, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_asserted("abort_low", 0);
      #1;
      rst_n = 1'b1;
      run_check("abort", 1, 12, 0, 0);

      // Software pulse at edge E: releases at E+4, E+7, E+10.
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      check_asserted("sw_E", 1);
      run_check("sw", 1, 10, 2, 1);

      // Held request during RELEASE with ch0 already released.
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      check_asserted("held_E", 2);
      run_check("held_pre", 1, 4, 2, 2);
      sw_rst_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_asserted("held_hi", 2);
      end
      sw_rst_req = 1'b0;
      run_check("held", 1, 10, 2, 2);

      // Single-channel instance: ch0 and done at edge 4, counter wraps modulo 4.
      #4;
      rst_n2 = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         step();
         check("p_out",   32'(rst_out2),   32'(n >= 4));
         check("p_done",  32'(done2),      32'(n >= 4));
         check("p_count", 32'(seq_count2), 32'(n >= 4));
      end
      for (int p = 1; p <= 5; p++) begin
         sw_rst_req2 = 1'b1;
         step();
         sw_rst_req2 = 1'b0;
         check("p_sw_out",   32'(rst_out2),   32'(0));
         check("p_sw_done",  32'(done2),      32'(0));
         check("p_sw_count", 32'(seq_count2), 32'(p % 4));
         step();
         check("p_rel_out",   32'(rst_out2),   32'(1));
         check("p_rel_done",  32'(done2),      32'(1));
         check("p_rel_count", 32'(seq_count2), 32'((p + 1) % 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
